// File: rtl/mem_access_unit_if.sv
//==============================================================================
// Module      : mem_access_unit_if
// Description : Pipeline-side request/response and data-memory bus signals of
//               the memory-stage access controller. The slave modport is the
//               controller's view; the master modport is the view of whatever
//               drives requests and models the memory.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_access_unit_if;
    // Pipeline request side
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    // Pipeline response side
    logic [31:0] load_data;
    logic        busywait;
    logic        misaligned;
    logic        bus_error;
    // Data-memory port
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byteen;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport slave (
        input  mem_read, mem_write, funct3, addr, store_data,
        input  dmem_rdata, dmem_ready,
        output load_data, busywait, misaligned, bus_error,
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byteen
    );

    modport master (
        output mem_read, mem_write, funct3, addr, store_data,
        output dmem_rdata, dmem_ready,
        input  load_data, busywait, misaligned, bus_error,
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byteen
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
//==============================================================================
// Module      : mem_access_unit
// Description : Memory-stage data access controller. Turns load/store requests
//               into word-aligned, byte-enabled transactions on a
//               variable-latency memory port, stalls the pipeline through
//               busywait until completion, and returns extended load data.
//               Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN
//               (defined: misaligned half/word accesses skip memory and
//               complete in one cycle with the misaligned flag set).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64   // ACCESS cycles before bus-error abort, 2..255
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    // Count value seen in the last permitted ACCESS cycle (count starts at 0)
    localparam logic [7:0] c_TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_cnt;

    logic [1:0]  r_lane;
    logic [2:0]  r_f3;
    logic        r_is_write;

    logic [31:0] r_load_data;
    logic        r_bus_error;
    logic        r_dmem_read;
    logic        r_dmem_write;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_byteen;

    logic        w_req;
    logic [2:0]  w_f3;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misalign;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;
    logic        w_ready_hit;
    logic        w_timeout;
    logic        w_busywait;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_req = bus.mem_read | bus.mem_write;

    // Unlisted funct3 codes collapse to word access
    always_comb begin
        w_f3 = 3'b010;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3 = bus.funct3;
            default:                                w_f3 = 3'b010;
        endcase
    end

    assign w_is_byte = (w_f3[1:0] == 2'b00);
    assign w_is_half = (w_f3[1:0] == 2'b01);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign w_misalign = w_req & ((w_is_half & bus.addr[0]) |
                                 (~w_is_byte & ~w_is_half & (bus.addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane enables and replicated write data; reads always fetch the full word
    always_comb begin
        w_byteen = 4'b1111;
        w_wdata  = bus.store_data;
        if (bus.mem_write) begin
            if (w_is_byte) begin
                w_byteen = 4'b0001 << bus.addr[1:0];
                w_wdata  = {4{bus.store_data[7:0]}};
            end else if (w_is_half) begin
                w_byteen = 4'b0011 << {bus.addr[1], 1'b0};
                w_wdata  = {2{bus.store_data[15:0]}};
            end
        end
    end

    assign w_ready_hit = (r_state == c_S_ACCESS) & bus.dmem_ready;
    assign w_timeout   = (r_state == c_S_ACCESS) & ~bus.dmem_ready & (r_cnt == c_TO_LAST);

    // Lane selection and sign/zero extension of the returned word
    always_comb begin
        w_byte = bus.dmem_rdata[7:0];
        case (r_lane)
            2'd0: w_byte = bus.dmem_rdata[7:0];
            2'd1: w_byte = bus.dmem_rdata[15:8];
            2'd2: w_byte = bus.dmem_rdata[23:16];
            default: w_byte = bus.dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = bus.dmem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; DONE never re-samples the request
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_req) begin
                    w_next_state = w_misalign ? c_S_DONE : c_S_ACCESS;
                end
            end
            c_S_ACCESS: begin
                if (w_ready_hit || w_timeout) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // FSM output logic: stall while a request waits in IDLE or is in flight
    always_comb begin
        w_busywait = ((r_state == c_S_IDLE) & w_req) | (r_state == c_S_ACCESS);
    end

    // ACCESS-cycle counter, cleared whenever the FSM is elsewhere
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_S_ACCESS)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Request capture, memory strobes, load result and bus-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane        <= 2'b00;
            r_f3          <= 3'b000;
            r_is_write    <= 1'b0;
            r_load_data   <= 32'h0;
            r_bus_error   <= 1'b0;
            r_dmem_read   <= 1'b0;
            r_dmem_write  <= 1'b0;
            r_dmem_addr   <= 32'h0;
            r_dmem_wdata  <= 32'h0;
            r_dmem_byteen <= 4'b0000;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_req) begin
                        r_lane     <= bus.addr[1:0];
                        r_f3       <= w_f3;
                        r_is_write <= bus.mem_write;
                        if (w_misalign) begin
                            r_load_data <= 32'h0;
                        end else begin
                            // A write wins when both request bits are set
                            r_dmem_read   <= ~bus.mem_write;
                            r_dmem_write  <= bus.mem_write;
                            r_dmem_addr   <= {bus.addr[31:2], 2'b00};
                            r_dmem_wdata  <= w_wdata;
                            r_dmem_byteen <= w_byteen;
                        end
                    end
                end
                c_S_ACCESS: begin
                    if (w_ready_hit) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_load_data  <= r_is_write ? 32'h0 : w_ext;
                    end else if (w_timeout) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_bus_error  <= 1'b1;
                        r_load_data  <= 32'h0;
                    end
                end
                c_S_DONE: begin
                    r_bus_error <= 1'b0;
                end
                default: begin
                    r_bus_error <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic r_misaligned;

    // Misaligned flag: raised on the trap's IDLE->DONE edge, cleared leaving DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else if (r_state == c_S_DONE) begin
            r_misaligned <= 1'b0;
        end else if ((r_state == c_S_IDLE) && w_misalign) begin
            r_misaligned <= 1'b1;
        end
    end

    assign bus.misaligned = r_misaligned;
`else
    assign bus.misaligned = 1'b0;
`endif

    assign bus.busywait    = w_busywait;
    assign bus.load_data   = r_load_data;
    assign bus.bus_error   = r_bus_error;
    assign bus.dmem_read   = r_dmem_read;
    assign bus.dmem_write  = r_dmem_write;
    assign bus.dmem_addr   = r_dmem_addr;
    assign bus.dmem_wdata  = r_dmem_wdata;
    assign bus.dmem_byteen = r_dmem_byteen;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: a vector table of
//               single transactions plus hand-written multi-cycle sequences
//               (delayed ready, stray ready, reset mid-access, timeout).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_unit;

    logic clk;
    logic rst;
    logic t_gate;
    int   n_checks;
    int   n_err;

    mem_access_unit_if ifc ();
    mem_access_unit_if ifc_t ();

    // Second instance with a short timeout mirrors the main stimulus; its ready can be gated off
    assign ifc_t.mem_read   = ifc.mem_read;
    assign ifc_t.mem_write  = ifc.mem_write;
    assign ifc_t.funct3     = ifc.funct3;
    assign ifc_t.addr       = ifc.addr;
    assign ifc_t.store_data = ifc.store_data;
    assign ifc_t.dmem_rdata = ifc.dmem_rdata;
    assign ifc_t.dmem_ready = ifc.dmem_ready & t_gate;

    mem_access_unit #(.TIMEOUT_CYCLES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (ifc_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdv;
        int          rdy_at;
        int          stall;
        logic [31:0] ld;
        logic        chk_ld;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        mis;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.mem_read = 1'b0;
        ifc.mem_write = 1'b0;
        ifc.dmem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One complete transaction starting from IDLE, checked cycle by cycle
    task automatic access(input string nm, input vec_t v);
        int   cyc;
        int   stall;
        logic bad;
        logic exp_rs;
        logic exp_ws;
        exp_ws = v.wr & ~v.mis;
        exp_rs = v.rd & ~v.wr & ~v.mis;
        ifc.mem_read   = v.rd;
        ifc.mem_write  = v.wr;
        ifc.funct3     = v.f3;
        ifc.addr       = v.a;
        ifc.store_data = v.sd;
        ifc.dmem_rdata = v.rdv;
        ifc.dmem_ready = 1'b0;
        #1;
        cyc = 0;
        stall = 0;
        bad = 1'b0;
        while (ifc.busywait === 1'b1 && cyc < 300) begin
            stall++;
            if (cyc >= 1) begin
                if (ifc.dmem_read !== exp_rs || ifc.dmem_write !== exp_ws ||
                    ifc.dmem_addr !== v.ad || ifc.dmem_byteen !== v.be ||
                    (exp_ws && ifc.dmem_wdata !== v.wd))
                    bad = 1'b1;
            end
            ifc.dmem_ready = (cyc == v.rdy_at);
            step();
            ifc.dmem_ready = 1'b0;
            cyc++;
        end
        chk({nm, " stall"}, stall, v.stall);
        chk({nm, " strobes"}, {31'd0, bad}, 32'd0);
        chk({nm, " done_strobes"}, {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        if (v.chk_ld) chk({nm, " load_data"}, ifc.load_data, v.ld);
        chk({nm, " misaligned"}, {31'd0, ifc.misaligned}, {31'd0, v.mis});
        chk({nm, " bus_error"}, {31'd0, ifc.bus_error}, 32'd0);
        ifc.mem_read  = 1'b0;
        ifc.mem_write = 1'b0;
        step();
        chk({nm, " flags_clr"}, {30'd0, ifc.misaligned, ifc.bus_error}, 32'd0);
        if (v.chk_ld) chk({nm, " ld_hold"}, ifc.load_data, v.ld);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        int stall;
        n_checks = 0;
        n_err = 0;
        t_gate = 1'b1;
        rst = 1'b1;
        ifc.mem_read = 1'b1;
        ifc.mem_write = 1'b0;
        ifc.funct3 = 3'b010;
        ifc.addr = 32'h0;
        ifc.store_data = 32'h0;
        ifc.dmem_rdata = 32'h0;
        ifc.dmem_ready = 1'b0;

        //        rd    wr    f3      addr          store         rdata         rdy st  load          chk   dmem_addr     wdata         be       mis
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 1, 2, 32'hDEADBEEF, 1'b1, 32'h00000100, 32'h0,        4'b1111, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FFFFFF, 1, 2, 32'hFFFFFF80, 1'b1, 32'h00000100, 32'h0,        4'b1111, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80FFFFFF, 1, 2, 32'h00000080, 1'b1, 32'h00000100, 32'h0,        4'b1111, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h00000202, 32'h0,        32'h80017FFF, 1, 2, 32'hFFFF8001, 1'b1, 32'h00000200, 32'h0,        4'b1111, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h00000200, 32'h0,        32'h8001F00D, 1, 2, 32'h0000F00D, 1'b1, 32'h00000200, 32'h0,        4'b1111, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0,        32'h12345678, 1, 2, 32'h00000056, 1'b1, 32'h00000100, 32'h0,        4'b1111, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'b000, 32'h00000003, 32'h0000007E, 32'h55555555, 1, 2, 32'h00000000, 1'b1, 32'h00000000, 32'h7E7E7E7E, 4'b1000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h00000202, 32'h1234ABCD, 32'h0,        1, 2, 32'h0,        1'b0, 32'h00000200, 32'hABCDABCD, 4'b1100, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h00000201, 32'h000000A5, 32'h0,        1, 2, 32'h0,        1'b0, 32'h00000200, 32'hA5A5A5A5, 4'b0010, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h00000304, 32'hCAFEF00D, 32'h0,        1, 2, 32'h0,        1'b0, 32'h00000304, 32'hCAFEF00D, 4'b1111, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000010C, 32'h0,        32'h89ABCDEF, 1, 2, 32'h89ABCDEF, 1'b1, 32'h0000010C, 32'h0,        4'b1111, 1'b0};
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h00000101, 32'h0,        32'h11223344, 1, 1, 32'h00000000, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h00000203, 32'h00005A5A, 32'h0,        1, 1, 32'h00000000, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b1};
`else
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h00000101, 32'h0,        32'h11223344, 1, 2, 32'h11223344, 1'b1, 32'h00000100, 32'h0,        4'b1111, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h00000203, 32'h00005A5A, 32'h0,        1, 2, 32'h0,        1'b0, 32'h00000200, 32'h5A5A5A5A, 4'b1100, 1'b0};
`endif
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h00000400, 32'h0,        32'h0BADF00D, 5, 6, 32'h0BADF00D, 1'b1, 32'h00000400, 32'h0,        4'b1111, 1'b0};

        // Reset state; busywait follows the request even while in reset
        step();
        step();
        chk("rst busywait_req", {31'd0, ifc.busywait}, 32'd1);
        chk("rst load_data", ifc.load_data, 32'h0);
        chk("rst strobes", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        chk("rst dmem_addr", ifc.dmem_addr, 32'h0);
        chk("rst dmem_wdata", ifc.dmem_wdata, 32'h0);
        chk("rst byteen", {28'd0, ifc.dmem_byteen}, 32'd0);
        chk("rst flags", {30'd0, ifc.misaligned, ifc.bus_error}, 32'd0);
        ifc.mem_read = 1'b0;
        #1;
        chk("rst busywait_idle", {31'd0, ifc.busywait}, 32'd0);
        rst = 1'b0;
        step();
        chk("nomem busywait", {31'd0, ifc.busywait}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            access($sformatf("vec%0d", i), vecs[i]);
        end

        // Ready pulse while idle must be ignored
        ifc.dmem_rdata = 32'hFFFFFFFF;
        ifc.dmem_ready = 1'b1;
        #1;
        chk("stray busywait", {31'd0, ifc.busywait}, 32'd0);
        step();
        ifc.dmem_ready = 1'b0;
        step();
        chk("stray load_hold", ifc.load_data, 32'h0BADF00D);
        chk("stray strobes", {30'd0, ifc.dmem_read, ifc.dmem_write}, 32'd0);
        chk("stray busywait2", {31'd0, ifc.busywait}, 32'd0);

        // Reset during the second ACCESS cycle aborts without completion
        ifc.mem_read = 1'b1;
        ifc.funct3 = 3'b010;
        ifc.addr = 32'h00000600;
        #1;
        chk("mr cycle0_busy", {31'd0, ifc.busywait}, 32'd1);
        step();
        chk("mr acc1_read", {31'd0, ifc.dmem_read}, 32'd1);
        step();
        chk("mr acc2_busy", {31'd0, ifc.busywait}, 32'd1);
        rst = 1'b1;
        step();
        chk("mr read_drop", {31'd0, ifc.dmem_read}, 32'd0);
        chk("mr load_zero", ifc.load_data, 32'h0);
        chk("mr bus_error", {31'd0, ifc.bus_error}, 32'd0);
        chk("mr busy_in_rst", {31'd0, ifc.busywait}, 32'd1);
        ifc.mem_read = 1'b0;
        #1;
        chk("mr busy_noreq", {31'd0, ifc.busywait}, 32'd0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("mr no_done_load", ifc.load_data, 32'h0);
        chk("mr no_done_flags", {30'd0, ifc.misaligned, ifc.bus_error}, 32'd0);

        // Timeout on the short-timeout instance
        do_reset();
        t_gate = 1'b1;
        access("tpre", vecs[0]);
        chk("t pre_load", ifc_t.load_data, 32'hDEADBEEF);
        t_gate = 1'b0;
        ifc.mem_read = 1'b1;
        ifc.funct3 = 3'b010;
        ifc.addr = 32'h00000500;
        ifc.dmem_rdata = 32'h13579BDF;
        #1;
        cyc = 0;
        stall = 0;
        while (ifc_t.busywait === 1'b1 && cyc < 50) begin
            stall++;
            step();
            cyc++;
        end
        chk("t stall", stall, 32'd5);
        chk("t bus_error", {31'd0, ifc_t.bus_error}, 32'd1);
        chk("t load_zero", ifc_t.load_data, 32'h0);
        chk("t read_drop", {31'd0, ifc_t.dmem_read}, 32'd0);
        chk("t main_still_busy", {31'd0, ifc.busywait}, 32'd1);
        ifc.mem_read = 1'b0;
        step();
        chk("t flag_clr", {31'd0, ifc_t.bus_error}, 32'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
